// File: rtl/pr_loopback_array_if.sv
// Handshake bundle for the loopback array: per-channel input/output streams,
// global transform mode and decouple, plus status outputs.
interface pr_loopback_array_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic                       decouple;
    logic [1:0]                 mode;
    logic [NUM_CH-1:0]          in_valid;
    logic [NUM_CH*DATA_W-1:0]   in_data;
    logic [NUM_CH-1:0]          in_ready;
    logic [NUM_CH-1:0]          out_valid;
    logic [NUM_CH*DATA_W-1:0]   out_data;
    logic [NUM_CH-1:0]          out_ready;
    logic [NUM_CH*CNT_W-1:0]    pkt_count;
    logic                       busy;

    // Shell side: produces input words and consumes output words.
    modport master (
        output decouple, mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, pkt_count, busy
    );

    // Reconfigurable-module side.
    modport slave (
        input  decouple, mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, pkt_count, busy
    );
endinterface

// File: rtl/pr_loopback_array.sv
// NUM_CH independent loopback channels. Each channel buffers up to DEPTH words,
// transforms them on enqueue and counts popped words. Decouple gates every
// handshake without disturbing stored state.
module pr_loopback_array #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 32
) (
    input  logic clock,
    input  logic reset,
    pr_loopback_array_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int NBYTE = DATA_W / 8;

    logic [NUM_CH-1:0]        in_ready_w;
    logic [NUM_CH-1:0]        out_valid_w;
    logic [NUM_CH-1:0]        nonempty_w;
    logic [NUM_CH*DATA_W-1:0] out_data_w;
    logic [NUM_CH*CNT_W-1:0]  pkt_count_w;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [DATA_W-1:0] CH_IDX = DATA_W'(gi);

            logic [DATA_W-1:0] mem [DEPTH];
            logic [PTR_W-1:0]  wr_ptr_reg;
            logic [PTR_W-1:0]  rd_ptr_reg;
            logic [OCC_W-1:0]  occ_reg;
            logic [CNT_W-1:0]  cnt_reg;
            logic              full;
            logic              empty;
            logic              push;
            logic              pop;
            logic [DATA_W-1:0] in_word;
            logic [DATA_W-1:0] rev_word;
            logic [DATA_W-1:0] stored_next;

            assign in_word = bus.in_data[gi*DATA_W +: DATA_W];
            assign full    = (occ_reg == OCC_W'(DEPTH));
            assign empty   = (occ_reg == '0);

            // Handshakes depend on registered state only; reset and decouple gate them.
            assign in_ready_w[gi]  = !full && !bus.decouple && !reset;
            assign out_valid_w[gi] = !empty && !bus.decouple;
            assign nonempty_w[gi]  = !empty;
            assign push = bus.in_valid[gi] && in_ready_w[gi];
            assign pop  = out_valid_w[gi] && bus.out_ready[gi];

            assign out_data_w[gi*DATA_W +: DATA_W] = mem[rd_ptr_reg];
            assign pkt_count_w[gi*CNT_W +: CNT_W]  = cnt_reg;

            // Enqueue transform selected by the mode present on the push edge.
            always_comb begin
                rev_word = '0;
                for (int b = 0; b < NBYTE; b++) begin
                    rev_word[b*8 +: 8] = in_word[(NBYTE-1-b)*8 +: 8];
                end
                case (bus.mode)
                    2'd0:    stored_next = in_word;
                    2'd1:    stored_next = ~in_word;
                    2'd2:    stored_next = in_word + CH_IDX;
                    default: stored_next = rev_word;
                endcase
            end

            // Pointers, occupancy and pop counter; reset empties the channel at once.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    occ_reg    <= '0;
                    cnt_reg    <= '0;
                end else begin
                    if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                        cnt_reg    <= cnt_reg + 1'b1;
                    end
                    case ({push, pop})
                        2'b10:   occ_reg <= occ_reg + 1'b1;
                        2'b01:   occ_reg <= occ_reg - 1'b1;
                        default: occ_reg <= occ_reg;
                    endcase
                end
            end

            // Storage array; contents need no reset because occupancy qualifies them.
            always_ff @(posedge clock) begin
                if (push) mem[wr_ptr_reg] <= stored_next;
            end
        end
    endgenerate

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = out_data_w;
    assign bus.pkt_count = pkt_count_w;
    assign bus.busy      = |nonempty_w;
endmodule

// File: tb/tb_pr_loopback_array.sv
// Randomized and directed checks of pr_loopback_array against a queue-based
// reference model (NUM_CH=4, DATA_W=32, DEPTH=4, CNT_W=4).
module tb_pr_loopback_array;
    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int DEP = 4;
    localparam int CW  = 4;

    logic clock;
    logic reset;

    pr_loopback_array_if #(.NUM_CH(NCH), .DATA_W(DW), .CNT_W(CW)) bus ();

    pr_loopback_array #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEP), .CNT_W(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: one FIFO queue and one pop count per channel.
    logic [31:0] q [NCH][$];
    int          pops [NCH];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] xform(input logic [1:0] md, input int c, input logic [31:0] x);
        case (md)
            2'd0:    return x;
            2'd1:    return ~x;
            2'd2:    return x + 32'(c);
            default: return {x[7:0], x[15:8], x[23:16], x[31:24]};
        endcase
    endfunction

    function automatic logic [127:0] lane(input int c, input logic [31:0] v);
        logic [127:0] d;
        d = '0;
        d[c*32 +: 32] = v;
        return d;
    endfunction

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic step(input logic dec, input logic [1:0] md, input logic [3:0] iv,
                        input logic [127:0] id, input logic [3:0] ordy);
        logic rdy_e, vld_e;
        logic [31:0] w;
        @(negedge clock);
        bus.decouple  = dec;
        bus.mode      = md;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        #1;
        check_val("busy", 64'(bus.busy), 64'(q[0].size() + q[1].size() + q[2].size() + q[3].size() != 0));
        for (int c = 0; c < NCH; c++) begin
            rdy_e = (q[c].size() < DEP) && !dec;
            vld_e = (q[c].size() > 0) && !dec;
            check_val($sformatf("in_ready%0d", c), 64'(bus.in_ready[c]), 64'(rdy_e));
            check_val($sformatf("out_valid%0d", c), 64'(bus.out_valid[c]), 64'(vld_e));
            if (q[c].size() > 0)
                check_val($sformatf("out_data%0d", c), 64'(bus.out_data[c*32 +: 32]), 64'(q[c][0]));
            check_val($sformatf("pkt_count%0d", c), 64'(bus.pkt_count[c*CW +: CW]), 64'(pops[c] % 16));
            if (vld_e && ordy[c]) begin
                w = q[c].pop_front();
                pops[c]++;
            end
            if (rdy_e && iv[c]) q[c].push_back(xform(md, c, id[c*32 +: 32]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_in_ready"},  64'(bus.in_ready), 64'd0);
        check_val({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check_val({tag, "_busy"},      64'(bus.busy), 64'd0);
        check_val({tag, "_pkt_count"}, 64'(bus.pkt_count), 64'd0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.decouple  = 1'b0;
        bus.mode      = 2'd0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = '0;
        for (int c = 0; c < NCH; c++) pops[c] = 0;
        #3;
        check_reset_outputs("reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Single word round trip with pass-through mode.
        step(0, 2'd0, 4'b0001, lane(0, 32'hDEADBEEF), 4'hF);
        step(0, 2'd0, 4'b0000, '0, 4'hF);
        step(0, 2'd0, 4'b0000, '0, 4'hF);
        check_val("deadbeef_count", 64'(bus.pkt_count[0 +: CW]), 64'd1);

        // Each transform; buffered words hold while the mode changes.
        step(0, 2'd1, 4'b0001, lane(0, 32'h0000FFFF), 4'h0);
        step(0, 2'd2, 4'b1000, lane(3, 32'h00000010), 4'h0);
        step(0, 2'd3, 4'b0010, lane(1, 32'h11223344), 4'h0);
        step(0, 2'd0, 4'b0000, '0, 4'h0);
        check_val("inv_word", 64'(bus.out_data[0 +: 32]), 64'h0000_0000_FFFF_0000);
        check_val("add_word", 64'(bus.out_data[96 +: 32]), 64'h0000_0000_0000_0013);
        check_val("rev_word", 64'(bus.out_data[32 +: 32]), 64'h0000_0000_4433_2211);
        step(0, 2'd0, 4'b0000, '0, 4'hF);

        // Back-pressure on ch2: five words, the fifth stalls until draining starts.
        for (int k = 1; k <= 5; k++) step(0, 2'd0, 4'b0100, lane(2, 32'(k)), 4'h0);
        step(0, 2'd0, 4'b0100, lane(2, 32'd5), 4'h0);
        for (int k = 0; k < 7; k++) step(0, 2'd0, 4'b0100, lane(2, 32'd5), 4'b0100);

        // Full ch0 with simultaneous pop request and new word.
        for (int k = 0; k < 4; k++) step(0, 2'd0, 4'b0001, lane(0, 32'h100 + 32'(k)), 4'h0);
        step(0, 2'd0, 4'b0001, lane(0, 32'h1FF), 4'b0001);
        step(0, 2'd0, 4'b0001, lane(0, 32'h200), 4'h0);
        for (int k = 0; k < 6; k++) step(0, 2'd0, 4'b0000, '0, 4'hF);

        // Steady streaming on a half-full buffer.
        step(0, 2'd0, 4'b0001, lane(0, 32'hA0), 4'h0);
        step(0, 2'd0, 4'b0001, lane(0, 32'hA1), 4'h0);
        for (int k = 0; k < 6; k++) step(0, 2'd0, 4'b0001, lane(0, 32'hB0 + 32'(k)), 4'b0001);
        for (int k = 0; k < 3; k++) step(0, 2'd0, 4'b0000, '0, 4'hF);

        // Decouple freezes everything; contents resume intact.
        step(0, 2'd0, 4'hF, {32'h31, 32'h21, 32'h11, 32'h01}, 4'h0);
        step(0, 2'd0, 4'hF, {32'h32, 32'h22, 32'h12, 32'h02}, 4'h0);
        for (int k = 0; k < 10; k++) step(1, 2'd1, 4'hF, {4{$urandom}}, 4'hF);
        for (int k = 0; k < 3; k++) step(0, 2'd0, 4'h0, '0, 4'hF);

        // Counter wrap on ch1 (4-bit counter).
        for (int k = 0; k < 18; k++) step(0, 2'd0, 4'b0010, lane(1, 32'(k)), 4'b0010);
        step(0, 2'd0, 4'b0000, '0, 4'hF);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++)
            step(($urandom_range(0, 19) == 0), 2'($urandom), 4'($urandom),
                 {$urandom, $urandom, $urandom, $urandom}, 4'($urandom));

        // Reset mid-stream: load words, then assert reset between edges.
        for (int k = 0; k < 3; k++) step(0, 2'd0, 4'hF, {4{$urandom}}, 4'h0);
        @(negedge clock);
        bus.in_valid = 4'hF;
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        for (int c = 0; c < NCH; c++) begin
            q[c].delete();
            pops[c] = 0;
        end
        @(negedge clock);
        check_reset_outputs("midreset_hold");
        reset = 1'b0;
        bus.in_valid = 4'h0;
        for (int k = 0; k < 4; k++) step(0, 2'd0, 4'hF, {4{$urandom}}, 4'hF);
        for (int k = 0; k < 4; k++) step(0, 2'd0, 4'h0, '0, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pr_loopback_array.md
Name: pr_loopback_array

Overview:
Parametrised successor to the single-word PR loopback reconfigurable module. It instantiates NUM_CH independent loopback channels, each with a valid/ready handshake, a DEPTH-entry buffer, a per-word transform mode and a popped-word counter. A decouple input isolates all channel handshakes while the region is being reconfigured. It sits inside each reconfigurable partition, clocked by the shell's system clock.

Parameters:
NUM_CH, 4, number of independent loopback channels (>=1)
DATA_W, 32, data width per channel in bits (multiple of 8)
DEPTH, 4, buffer entries per channel (power of 2, >=2)
CNT_W, 32, width of each per-channel popped-word counter

Ports:
clock  in  1  system clock; all logic on the rising edge
reset  in  1  asynchronous, active-high reset
decouple  in  1  1 = isolate all channels (PR in progress)
mode  in  2  transform applied at enqueue: 0 pass, 1 invert, 2 add channel index, 3 byte-reverse
in_valid  in  NUM_CH  per-channel input valid
in_data  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
in_ready  out  NUM_CH  per-channel input ready
out_valid  out  NUM_CH  per-channel output valid
out_data  out  NUM_CH*DATA_W  packed the same way as in_data
out_ready  in  NUM_CH  per-channel output ready
pkt_count  out  NUM_CH*CNT_W  per-channel count of popped words, packed like in_data
busy  out  1  OR over all channels of (occupancy != 0)

Behaviour:
- Reset (async assert, sync release in the shell): all read/write pointers and occupancy cleared, pkt_count = 0, out_valid = 0, busy = 0. in_ready is forced to 0 while reset is high.
- Per channel c:
  - push = in_valid[c] & in_ready[c]
  - pop = out_valid[c] & out_ready[c]
  - in_ready[c] = !full & !decouple & !reset. It is combinational from registered state only, so no path from in_valid.
  - out_valid[c] = !empty & !decouple
  - out_data = head entry. Storage is registered; no fall-through.
- Latency: a word pushed on edge T is presented on out_data/out_valid after edge T, i.e. valid in cycle T+1. Minimum round trip is 1 cycle.
- Transform at enqueue, using mode sampled on the push edge:
  - mode 0: stored = in
  - mode 1: stored = ~in
  - mode 2: stored = in + c, modulo 2^DATA_W
  - mode 3: stored = in with byte order reversed
  - Changing mode never alters words already buffered.
- Occupancy:
  - Ranges 0..DEPTH.
  - full = (occupancy == DEPTH); empty = (occupancy == 0).
  - Pointers are log2(DEPTH) bits and wrap naturally.
- Simultaneous events:
  - Push and pop in the same cycle when neither full nor empty: occupancy unchanged, data order preserved.
  - When full: in_ready = 0, so a same-cycle pop does not allow a push. Occupancy becomes DEPTH-1 and in_ready rises next cycle.
  - When empty: out_valid = 0, so no pop occurs.
- pkt_count[c] increments by 1 on each pop and wraps from 2^CNT_W-1 to 0. It is unaffected by mode.
- decouple = 1:
  - in_ready and out_valid are forced to 0 in the same cycle (combinational gate).
  - Buffer contents, pointers and counters are held.
  - out_data still shows the head entry, and downstream must ignore it.
  - Deasserting decouple resumes with all contents intact.
- Protocol:
  - out_data/out_valid stay stable while out_valid = 1 and out_ready = 0, unless decouple rises.
  - Channels are fully independent; no cross-channel arbitration.
- Reset mid-stream: all buffered words are discarded immediately and counters clear asynchronously.

Test Plan:
- Reset, then mode=0; push 0xDEADBEEF on ch0 with out_ready=1 -> out_valid[0] in the next cycle, out_data ch0 = 0xDEADBEEF, pkt_count[0] = 1, busy returns to 0.
- mode=1 push 0x0000FFFF, mode=2 push 0x10 on ch3, mode=3 push 0x11223344 on ch1 -> outputs 0xFFFF0000, 0x13, 0x44332211 respectively. Switching mode after a push leaves that buffered word unchanged.
- out_ready=0 on ch2, push 5 words 1..5 with DEPTH=4 -> in_ready[2] falls after word 4 and word 5 stalls. Releasing out_ready drains 1,2,3,4, then word 5 is accepted; no loss, no duplication.
- Full ch0 with out_ready=1 and in_valid=1 -> no push on the pop cycle, occupancy 4->3, in_ready=1 the next cycle. Continuous streaming on a half-full buffer holds occupancy constant.
- Load 2 words per channel, assert decouple for 10 cycles -> all in_ready/out_valid = 0 and counts frozen. Deassert -> the same 2 words per channel emerge in order.
- With CNT_W=4, pop 17 words on ch1 -> pkt_count[1] = 1. Assert reset mid-stream -> out_valid=0, busy=0, counts=0 immediately, in_ready=0 until reset is released.
